// File: rtl/modulo_controle_jogada_pkg.sv
// Shared constants, mode encodings, FSM states and small helpers for the
// naval-battle play-control stage.
package pkg_jogo;

    localparam int GRID_ROWS = 7;
    localparam int GRID_COLS = 5;
    localparam int CELLS     = 35;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        MODE_CLEAR    = 2'b00,
        MODE_ATTACK   = 2'b01,
        MODE_POSITION = 2'b10,
        MODE_VIEW     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EVAL   = 2'b01,
        ST_COMMIT = 2'b10,
        ST_LOCK   = 2'b11
    } state_e;

    localparam logic [2:0] ROW_LIMIT = 3'(GRID_ROWS);
    localparam logic [2:0] COL_LIMIT = 3'(GRID_COLS);

    // Row-major cell index: row*5 + col, computed as row*4 + row + col.
    function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] row, input logic [2:0] col);
        logic [IDX_W-1:0] r;
        r = {3'b000, row};
        return (r << 2) + r + {3'b000, col};
    endfunction

    function automatic logic coord_valid(input logic [2:0] row, input logic [2:0] col);
        return (row < ROW_LIMIT) && (col < COL_LIMIT);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/modulo_controle_jogada_if.sv
// Bus between the play-control stage (master) and the board/display stages
// that supply mode, coordinate and ship map and consume the action strobes.
interface modulo_controle_jogada_if;
    import pkg_jogo::*;

    logic [1:0]       hh1;
    logic [5:0]       hh2;
    logic [CELLS-1:0] ship_map;

    logic             po_we;
    logic             clr_all;
    logic             at_we;
    logic [IDX_W-1:0] at_idx;
    logic             hit;
    logic             erro;
    logic [CNT_W-1:0] acertos;
    logic [CNT_W-1:0] tiros;
    logic             fim;

    modport master (
        input  hh1, hh2, ship_map,
        output po_we, clr_all, at_we, at_idx, hit, erro, acertos, tiros, fim
    );

    modport slave (
        output hh1, hh2, ship_map,
        input  po_we, clr_all, at_we, at_idx, hit, erro, acertos, tiros, fim
    );

endinterface

// File: rtl/modulo_debounce.sv
// Confirm-button conditioning: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted rising edge of the debounced level.
module modulo_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_n_i,
    output logic deb_o,
    output logic conf_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    // Chain resets to the released level so a reset never looks like a press.
    logic [1:0]       sync_chain_q;
    logic             sync;
    logic             deb_q, deb_d;
    logic             conf_q, conf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sync = ~sync_chain_q[1];

    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        conf_d = 1'b0;
        if (sync == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            deb_d  = sync;
            conf_d = sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_chain_q <= 2'b11;
            deb_q        <= 1'b0;
            conf_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[0], btn_n_i};
            deb_q        <= deb_d;
            conf_q       <= conf_d;
            cnt_q        <= cnt_d;
        end
    end

    assign deb_o  = deb_q;
    assign conf_o = conf_q;

endmodule

// File: rtl/modulo_controle_jogada.sv
// Play-control stage: one action per confirmed press, hit/shot counters and the
// game-over flag. Define REPEAT_CHECK_EN to reject attacks on already-shot cells.
module modulo_controle_jogada
    import pkg_jogo::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int SHIP_CELLS = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      btn_n,
    modulo_controle_jogada_if.master  bus
);

    localparam logic [CNT_W-1:0] SHIP_LIMIT = CNT_W'(SHIP_CELLS);

    logic deb;
    logic conf;

    modulo_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .clr     (clr),
        .btn_n_i (btn_n),
        .deb_o   (deb),
        .conf_o  (conf)
    );

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [5:0]       coord_q, coord_d;
    logic             po_we_q, po_we_d;
    logic             clr_all_q, clr_all_d;
    logic             at_we_q, at_we_d;
    logic [IDX_W-1:0] at_idx_q, at_idx_d;
    logic             hit_q, hit_d;
    logic             erro_q, erro_d;
    logic [CNT_W-1:0] acertos_q, acertos_d;
    logic [CNT_W-1:0] tiros_q, tiros_d;
    logic             fim_q, fim_d;

    logic [IDX_W-1:0] cell_idx;
    logic             coord_ok;
    logic             ship_hit;
    logic             repeat_shot;
    logic [63:0]      ship_by_idx;

    assign cell_idx = cell_index(coord_q[5:3], coord_q[2:0]);
    assign coord_ok = coord_valid(coord_q[5:3], coord_q[2:0]);

    // Re-index the ship map by cell number, zero-padded so any 6-bit index is safe.
    for (genvar gi = 0; gi < 64; gi++) begin : g_ship
        if (gi < CELLS) begin : g_cell
            assign ship_by_idx[gi] = bus.ship_map[CELLS-1-gi];
        end else begin : g_pad
            assign ship_by_idx[gi] = 1'b0;
        end
    end

    assign ship_hit = ship_by_idx[cell_idx];

`ifdef REPEAT_CHECK_EN
    logic [CELLS-1:0] shot_q, shot_d;
    logic [63:0]      shot_view;

    for (genvar gi = 0; gi < 64; gi++) begin : g_shot
        if (gi < CELLS) begin : g_cell
            assign shot_view[gi] = shot_q[gi];
        end else begin : g_pad
            assign shot_view[gi] = 1'b0;
        end
    end

    assign repeat_shot = shot_view[cell_idx];
`else
    assign repeat_shot = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        coord_d   = coord_q;
        po_we_d   = 1'b0;
        clr_all_d = 1'b0;
        at_we_d   = 1'b0;
        at_idx_d  = at_idx_q;
        hit_d     = hit_q;
        erro_d    = erro_q;
        acertos_d = acertos_q;
        tiros_d   = tiros_q;
        fim_d     = fim_q | (acertos_q >= SHIP_LIMIT);
`ifdef REPEAT_CHECK_EN
        shot_d    = shot_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (conf) begin
                    mode_d  = mode_e'(bus.hh1);
                    coord_d = bus.hh2;
                    state_d = ST_EVAL;
                end
            end

            ST_EVAL: begin
                state_d = ST_COMMIT;
                unique case (mode_q)
                    MODE_CLEAR: begin
                        clr_all_d = 1'b1;
                        hit_d     = 1'b0;
                        erro_d    = 1'b0;
                        fim_d     = 1'b0;
                    end
                    MODE_POSITION: begin
                        // Ship layout is frozen once the first shot has been taken.
                        if (tiros_q != '0) begin
                            erro_d = 1'b1;
                        end else begin
                            po_we_d = 1'b1;
                            erro_d  = 1'b0;
                        end
                    end
                    MODE_ATTACK: begin
                        if (!coord_ok) begin
                            erro_d = 1'b1;
                        end else if (!fim_q) begin
                            if (repeat_shot) begin
                                erro_d = 1'b1;
                            end else begin
                                at_we_d  = 1'b1;
                                at_idx_d = cell_idx;
                                hit_d    = ship_hit;
                                erro_d   = 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end

            ST_COMMIT: begin
                state_d = ST_LOCK;
                if (clr_all_q) begin
                    acertos_d = '0;
                    tiros_d   = '0;
                    fim_d     = 1'b0;
`ifdef REPEAT_CHECK_EN
                    shot_d    = '0;
`endif
                end else if (at_we_q) begin
                    tiros_d   = sat_inc(tiros_q, 1'b1);
                    acertos_d = sat_inc(acertos_q, hit_q);
`ifdef REPEAT_CHECK_EN
                    shot_d[at_idx_q] = 1'b1;
`endif
                end
            end

            ST_LOCK: begin
                if (!deb) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_CLEAR;
            coord_q   <= '0;
            po_we_q   <= 1'b0;
            clr_all_q <= 1'b0;
            at_we_q   <= 1'b0;
            at_idx_q  <= '0;
            hit_q     <= 1'b0;
            erro_q    <= 1'b0;
            acertos_q <= '0;
            tiros_q   <= '0;
            fim_q     <= 1'b0;
`ifdef REPEAT_CHECK_EN
            shot_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            coord_q   <= coord_d;
            po_we_q   <= po_we_d;
            clr_all_q <= clr_all_d;
            at_we_q   <= at_we_d;
            at_idx_q  <= at_idx_d;
            hit_q     <= hit_d;
            erro_q    <= erro_d;
            acertos_q <= acertos_d;
            tiros_q   <= tiros_d;
            fim_q     <= fim_d;
`ifdef REPEAT_CHECK_EN
            shot_q    <= shot_d;
`endif
        end
    end

    assign bus.po_we   = po_we_q;
    assign bus.clr_all = clr_all_q;
    assign bus.at_we   = at_we_q;
    assign bus.at_idx  = at_idx_q;
    assign bus.hit     = hit_q;
    assign bus.erro    = erro_q;
    assign bus.acertos = acertos_q;
    assign bus.tiros   = tiros_q;
    assign bus.fim     = fim_q;

endmodule
